// File: rtl/alu_mc_param.sv
// alu_mc_param: handshaked parametrised ALU with full-width multiply and iterative restoring divider
module alu_mc_param #(
  parameter int WIDTH      = 16,
  parameter bit SHIFT_BY_B = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [3:0]       ALU_FUN,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] ALU_OUT,
  output logic [WIDTH-1:0] ALU_OUT_HI,
  output logic             ARITH_FLAG,
  output logic             LOGIC_FLAG,
  output logic             CMP_FLAG,
  output logic             SHIFT_FLAG,
  output logic             CARRY_FLAG,
  output logic             ZERO_FLAG,
  output logic             DIV_ERR
);
  localparam int SW = $clog2(WIDTH);
  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [0:0] IDLE = 1'b0, DIV = 1'b1;
  logic [0:0]       state_q, state_d;
  logic             out_valid_q, out_valid_d, carry_q, carry_d, zero_q, zero_d, div_err_q, div_err_d;
  logic [3:0]       cls_q, cls_d;
  logic [WIDTH-1:0] alu_out_q, alu_out_d, alu_hi_q, alu_hi_d;
  logic [WIDTH-1:0] dvd_q, dvd_d, dvs_q, dvs_d, rem_q, rem_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [SW-1:0]    sh;
  logic [WIDTH:0]   sum, diff, trial;
  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0] res, res_hi, rem_nx, quo_nx;
  logic [3:0]       cls;
  logic             car, derr, fits, accept;
  assign in_ready = (state_q == IDLE) && (!out_valid_q || out_ready);
  assign accept   = in_valid && in_ready;
  always_comb begin
    sh     = SHIFT_BY_B ? B[SW-1:0] : SW'(1);
    sum    = {1'b0, A} + {1'b0, B};
    diff   = {1'b0, A} - {1'b0, B};
    prod   = {{WIDTH{1'b0}}, A} * {{WIDTH{1'b0}}, B};
    res    = '0;
    res_hi = '0;
    car    = 1'b0;
    derr   = 1'b0;
    case (ALU_FUN)
      4'd0:    {car, res} = sum;
      4'd1:    {car, res} = diff;
      4'd2:    {res_hi, res} = prod;
      4'd3:    begin res = '1; res_hi = A; derr = 1'b1; end
      4'd4:    res = A & B;
      4'd5:    res = A | B;
      4'd6:    res = ~(A & B);
      4'd7:    res = ~(A | B);
      4'd8:    res = A ^ B;
      4'd9:    res = ~(A ^ B);
      4'd10:   res = (A == B) ? WIDTH'(1) : '0;
      4'd11:   res = (A > B) ? WIDTH'(2) : '0;
      4'd12:   res = (A < B) ? WIDTH'(3) : '0;
      4'd13:   res = A >> sh;
      4'd14:   res = A << sh;
      default: res = '0;
    endcase
    cls = {ALU_FUN <= 4'd3, ALU_FUN >= 4'd4 && ALU_FUN <= 4'd9,
           ALU_FUN >= 4'd10 && ALU_FUN <= 4'd12, ALU_FUN == 4'd13 || ALU_FUN == 4'd14};
  end
  // One restoring step: bring in the next dividend bit, keep the trial difference if it did not borrow
  always_comb begin
    trial  = {rem_q, dvd_q[WIDTH-1]} - {1'b0, dvs_q};
    fits   = !trial[WIDTH];
    rem_nx = fits ? trial[WIDTH-1:0] : {rem_q[WIDTH-2:0], dvd_q[WIDTH-1]};
    quo_nx = {dvd_q[WIDTH-2:0], fits};
  end
  always_comb begin
    state_d     = state_q;
    out_valid_d = out_valid_q;
    alu_out_d   = alu_out_q;
    alu_hi_d    = alu_hi_q;
    cls_d       = cls_q;
    carry_d     = carry_q;
    zero_d      = zero_q;
    div_err_d   = div_err_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    rem_d       = rem_q;
    cnt_d       = cnt_q;
    if (state_q == DIV) begin
      dvd_d = quo_nx;
      rem_d = rem_nx;
      cnt_d = cnt_q - CW'(1);
      if (cnt_q == CW'(1)) begin
        state_d     = IDLE;
        out_valid_d = 1'b1;
        alu_out_d   = quo_nx;
        alu_hi_d    = rem_nx;
        cls_d       = 4'b1000;
        carry_d     = 1'b0;
        zero_d      = quo_nx == '0;
        div_err_d   = 1'b0;
      end
    end else if (accept && ALU_FUN == 4'd3 && B != '0) begin
      state_d     = DIV;
      out_valid_d = 1'b0;
      dvd_d       = A;
      dvs_d       = B;
      rem_d       = '0;
      cnt_d       = CW'(WIDTH);
    end else if (accept) begin
      out_valid_d = 1'b1;
      alu_out_d   = res;
      alu_hi_d    = res_hi;
      cls_d       = cls;
      carry_d     = car;
      zero_d      = ALU_FUN != 4'd15 && res == '0;
      div_err_d   = derr;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      out_valid_q <= 1'b0;
      alu_out_q   <= '0;
      alu_hi_q    <= '0;
      cls_q       <= '0;
      carry_q     <= 1'b0;
      zero_q      <= 1'b0;
      div_err_q   <= 1'b0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      rem_q       <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      out_valid_q <= out_valid_d;
      alu_out_q   <= alu_out_d;
      alu_hi_q    <= alu_hi_d;
      cls_q       <= cls_d;
      carry_q     <= carry_d;
      zero_q      <= zero_d;
      div_err_q   <= div_err_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      rem_q       <= rem_d;
      cnt_q       <= cnt_d;
    end
  end
  assign out_valid  = out_valid_q;
  assign ALU_OUT    = alu_out_q;
  assign ALU_OUT_HI = alu_hi_q;
  assign {ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG} = cls_q;
  assign CARRY_FLAG = carry_q;
  assign ZERO_FLAG  = zero_q;
  assign DIV_ERR    = div_err_q;
endmodule

// File: tb/tb_alu_mc_param.sv
// tb_alu_mc_param: randomized and directed checks of alu_mc_param against an arithmetic reference model
module tb_alu_mc_param;
  localparam int W = 16;
  logic clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [W-1:0] A = '0, B = '0;
  logic [3:0] ALU_FUN = '0;
  logic in_ready, out_valid, ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG, CARRY_FLAG, ZERO_FLAG, DIV_ERR;
  logic [W-1:0] ALU_OUT, ALU_OUT_HI;
  logic in_ready1, out_valid1, af1, lf1, cf1, sf1, carry1, zero1, derr1;
  logic [W-1:0] out1, hi1;
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_mc_param #(.WIDTH(W), .SHIFT_BY_B(1'b0)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .out_valid(out_valid), .out_ready(out_ready), .ALU_OUT(ALU_OUT), .ALU_OUT_HI(ALU_OUT_HI),
    .ARITH_FLAG(ARITH_FLAG), .LOGIC_FLAG(LOGIC_FLAG), .CMP_FLAG(CMP_FLAG), .SHIFT_FLAG(SHIFT_FLAG),
    .CARRY_FLAG(CARRY_FLAG), .ZERO_FLAG(ZERO_FLAG), .DIV_ERR(DIV_ERR));

  alu_mc_param #(.WIDTH(W), .SHIFT_BY_B(1'b1)) dut_sb (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .A(A), .B(B), .ALU_FUN(ALU_FUN),
    .out_valid(out_valid1), .out_ready(out_ready), .ALU_OUT(out1), .ALU_OUT_HI(hi1),
    .ARITH_FLAG(af1), .LOGIC_FLAG(lf1), .CMP_FLAG(cf1), .SHIFT_FLAG(sf1),
    .CARRY_FLAG(carry1), .ZERO_FLAG(zero1), .DIV_ERR(derr1));

  // {ALU_OUT, ALU_OUT_HI, arith, logic, cmp, shift, carry, zero, div_err, out_valid}
  function automatic logic [39:0] obs();
    return {ALU_OUT, ALU_OUT_HI, ARITH_FLAG, LOGIC_FLAG, CMP_FLAG, SHIFT_FLAG, CARRY_FLAG, ZERO_FLAG, DIV_ERR, out_valid};
  endfunction

  function automatic logic [39:0] obs_sb();
    return {out1, hi1, af1, lf1, cf1, sf1, carry1, zero1, derr1, out_valid1};
  endfunction

  function automatic logic [39:0] model(input int op, input int a, input int b, input bit sbb);
    int o, h, k;
    bit c, de;
    longint p;
    o = 0; h = 0; c = 1'b0; de = 1'b0;
    k = sbb ? b % 16 : 1;
    case (op)
      0: begin o = (a + b) % 65536; c = (a + b) > 65535; end
      1: begin o = (a - b + 65536) % 65536; c = a < b; end
      2: begin p = longint'(a) * longint'(b); o = int'(p % 65536); h = int'(p / 65536); end
      3: if (b == 0) begin o = 65535; h = a; de = 1'b1; end else begin o = a / b; h = a % b; end
      4: o = a & b;
      5: o = a | b;
      6: o = 65535 - (a & b);
      7: o = 65535 - (a | b);
      8: o = a ^ b;
      9: o = 65535 - (a ^ b);
      10: o = (a == b) ? 1 : 0;
      11: o = (a > b) ? 2 : 0;
      12: o = (a < b) ? 3 : 0;
      13: o = a / (1 << k);
      14: o = (a * (1 << k)) % 65536;
      default: o = 0;
    endcase
    return {o[15:0], h[15:0], op <= 3, op >= 4 && op <= 9, op >= 10 && op <= 12, op == 13 || op == 14,
            c, op != 15 && o == 0, de, 1'b1};
  endfunction

  task automatic issue(input int op, input int a, input int b);
    @(negedge clk);
    ALU_FUN = 4'(op); A = W'(a); B = W'(b); in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_result(output int n);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs() !== 40'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL reset got %h rdy %b exp 0 rdy 1", obs(), in_ready);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_sweep();
    int ops[14] = '{0, 1, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    logic [15:0] exp_out[14] = '{16'h00F7, 16'h004D, 16'h0000, 16'h00F7, 16'hFFFF, 16'hFF08, 16'h00F7,
                                 16'hFF08, 16'h0000, 16'h0002, 16'h0000, 16'h0051, 16'h0144, 16'h0000};
    for (int i = 0; i < 14; i++) begin
      issue(ops[i], 'h00A2, 'h0055);
      checks++;
      if (ALU_OUT !== exp_out[i]) begin
        errors++; $display("FAIL sweep_out op %0d got %h exp %h", ops[i], ALU_OUT, exp_out[i]);
      end
      checks++;
      if (obs() !== model(ops[i], 'h00A2, 'h0055, 1'b0)) begin
        errors++; $display("FAIL sweep_all op %0d got %h exp %h", ops[i], obs(), model(ops[i], 'h00A2, 'h0055, 1'b0));
      end
    end
  endtask

  task automatic test_edges();
    issue(2, 'hFFFF, 'hFFFF);
    checks++;
    if ({ALU_OUT, ALU_OUT_HI} !== 32'hFFFE_0001 >> 0 && {ALU_OUT_HI, ALU_OUT} !== 32'hFFFE_0001) begin
      errors++; $display("FAIL mul_max got hi %h lo %h exp hi fffe lo 0001", ALU_OUT_HI, ALU_OUT);
    end
    issue(0, 'hFFFF, 'h0001);
    checks++;
    if ({ALU_OUT, CARRY_FLAG, ZERO_FLAG, ARITH_FLAG} !== {16'h0000, 3'b111}) begin
      errors++; $display("FAIL add_wrap got out %h c %b z %b exp 0000 1 1", ALU_OUT, CARRY_FLAG, ZERO_FLAG);
    end
  endtask

  task automatic test_div();
    int n;
    bit busy_ok;
    issue(3, 162, 85);
    busy_ok = 1'b1;
    n = 0;
    while (!out_valid && n < 40) begin
      if (in_ready !== 1'b0) busy_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n != 16 || !busy_ok) begin
      errors++; $display("FAIL div_latency got %0d busy_ok %b exp 16 1", n, busy_ok);
    end
    checks++;
    if (obs() !== model(3, 162, 85, 1'b0)) begin
      errors++; $display("FAIL div_result got %h exp %h", obs(), model(3, 162, 85, 1'b0));
    end
    issue(3, 'h1234, 0);
    checks++;
    if (obs() !== model(3, 'h1234, 0, 1'b0) || ALU_OUT_HI !== 16'h1234 || DIV_ERR !== 1'b1) begin
      errors++; $display("FAIL div_zero got %h exp %h", obs(), model(3, 'h1234, 0, 1'b0));
    end
  endtask

  task automatic test_backpressure();
    logic [39:0] snap;
    bit stable = 1'b1;
    @(negedge clk); out_ready = 1'b1;
    @(negedge clk); out_ready = 1'b0;
    ALU_FUN = 4'd0; A = 16'h1111; B = 16'h2222; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    snap = obs();
    checks++;
    if (snap !== model(0, 'h1111, 'h2222, 1'b0)) begin
      errors++; $display("FAIL bp_first got %h exp %h", snap, model(0, 'h1111, 'h2222, 1'b0));
    end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      ALU_FUN = 4'd5; A = W'($urandom); B = W'($urandom); in_valid = 1'b1;
      if (obs() !== snap || in_ready !== 1'b0) stable = 1'b0;
    end
    in_valid = 1'b0;
    checks++;
    if (!stable) begin
      errors++; $display("FAIL bp_hold got %h rdy %b exp %h rdy 0", obs(), in_ready, snap);
    end
    @(negedge clk);
    out_ready = 1'b1; ALU_FUN = 4'd1; A = 16'h3000; B = 16'h0123; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    checks++;
    if (obs() !== model(1, 'h3000, 'h0123, 1'b0)) begin
      errors++; $display("FAIL bp_release got %h exp %h", obs(), model(1, 'h3000, 'h0123, 1'b0));
    end
  endtask

  task automatic test_rst_in_div();
    issue(3, 'hBEEF, 'h0013);
    repeat (6) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (obs() !== 40'h0 || in_ready !== 1'b1) begin
      errors++; $display("FAIL rst_div got %h rdy %b exp 0 rdy 1", obs(), in_ready);
    end
    @(negedge clk); rst = 1'b0;
    issue(0, 'h0102, 'h0304);
    checks++;
    if (obs() !== model(0, 'h0102, 'h0304, 1'b0)) begin
      errors++; $display("FAIL post_rst_add got %h exp %h", obs(), model(0, 'h0102, 'h0304, 1'b0));
    end
  endtask

  task automatic test_shift_by_b();
    issue(14, 'h8001, 3);
    checks++;
    if (out1 !== 16'h0008 || obs_sb() !== model(14, 'h8001, 3, 1'b1)) begin
      errors++; $display("FAIL shl_by_b got %h exp 0008", out1);
    end
    for (int i = 0; i < 10; i++) begin
      int op, a, b;
      op = 13 + (i % 2); a = int'($urandom_range(0, 65535)); b = int'($urandom_range(0, 65535));
      issue(op, a, b);
      checks++;
      if (obs_sb() !== model(op, a, b, 1'b1)) begin
        errors++; $display("FAIL shift_by_b op %0d got %h exp %h", op, obs_sb(), model(op, a, b, 1'b1));
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int i = 0; i < 150; i++) begin
      int op, a, b;
      op = int'($urandom_range(0, 15));
      a = int'($urandom_range(0, 65535));
      b = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 65535)) >> $urandom_range(0, 15);
      issue(op, a, b);
      if (op == 3 && b != 0) wait_result(n);
      checks++;
      if (obs() !== model(op, a, b, 1'b0)) begin
        errors++; $display("FAIL random op %0d a %h b %h got %h exp %h", op, a, b, obs(), model(op, a, b, 1'b0));
      end
    end
  endtask

  task automatic test_back_to_back();
    int a[4] = '{'h0010, 'h0F0F, 'h7FFF, 'h0003};
    int b[4] = '{'h0020, 'h00FF, 'h0001, 'h0003};
    int op[4] = '{0, 4, 11, 10};
    bit drop = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ALU_FUN = 4'(op[i]); A = W'(a[i]); B = W'(b[i]); in_valid = 1'b1;
      @(posedge clk); #1;
      if (out_valid !== 1'b1) drop = 1'b1;
      checks++;
      if (obs() !== model(op[i], a[i], b[i], 1'b0)) begin
        errors++; $display("FAIL b2b op %0d got %h exp %h", op[i], obs(), model(op[i], a[i], b[i], 1'b0));
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checks++;
    if (drop) begin
      errors++; $display("FAIL b2b_valid got drop 1 exp 0");
    end
  endtask

  initial begin
    test_reset();
    test_sweep();
    test_edges();
    test_div();
    test_backpressure();
    test_back_to_back();
    test_rst_in_div();
    test_shift_by_b();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got running exp finished");
    $fatal(1);
  end
endmodule
